clk_speed_sel: RTL and testbench

Clock-speed request controller sitting directly upstream of the HS/LS clock switch. It decodes each CPU bus cycle, decides whether it must run on the host (slow, motherboard-timed) clock or may run on the accelerator (fast) clock, and drives the switch's `hsclk_sel` request. It then tracks the switch's `hsclk_selected` / `lsclk_selected` feedback through synchronisers, holds CPU `rdy` low while a changeover is in flight, and flags changeovers that never complete.

---
 rtl/clk_speed_pkg.sv | 17 +
 rtl/clk_speed_sel_sync2.sv | 23 ++
 rtl/clk_speed_sel.sv | 134 +++++++++++++
 tb/tb_clk_speed_sel.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clk_speed_pkg.sv
// Shared definitions for the HS/LS clock-speed request controller.
package clk_speed_pkg;

   typedef enum logic [1:0] {
      ST_SLOW     = 2'd0,
      ST_REQ_FAST = 2'd1,
      ST_FAST     = 2'd2,
      ST_REQ_SLOW = 2'd3
   } speed_state_e;

   localparam logic [15:0] IO_LO_DEF = 16'hFC00;
   localparam logic [15:0] IO_HI_DEF = 16'hFEFF;

   localparam int HOLD_W = 8;
   localparam int TO_W   = 10;

endpackage

// File: rtl/clk_speed_sel_sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic hsclk_in,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge hsclk_in or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/clk_speed_sel.sv
// Decodes CPU bus cycles into fast/slow clock requests for the HS/LS switch,
// holds rdy low across changeovers and flags changeovers that never finish.
//
// state       | meaning
// ------------+--------------------------------------------------------
// SLOW        | running on host clock, counting fast-eligible cycles
// REQ_FAST    | hsclk_sel raised, waiting for switch to report HS
// FAST        | running on accelerator clock
// REQ_SLOW    | hsclk_sel dropped, waiting for switch to report LS
module clk_speed_sel
   import clk_speed_pkg::*;
#(
   parameter logic [15:0] IO_LO       = IO_LO_DEF,
   parameter logic [15:0] IO_HI       = IO_HI_DEF,
   parameter int          HOLD_CYCLES = 8,
   parameter int          TIMEOUT     = 1023
) (
   input  logic        hsclk_in,
   input  logic        rst,
   input  logic        cpu_valid,
   input  logic [7:0]  cpu_bank,
   input  logic [15:0] cpu_addr,
   input  logic        force_slow,
   input  logic        hsclk_selected,
   input  logic        lsclk_selected,
   output logic        hsclk_sel,
   output logic        rdy,
   output logic        err,
   output logic [1:0]  state_o
);

   localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(HOLD_CYCLES);
   localparam logic [TO_W-1:0]   TO_TC   = TO_W'(TIMEOUT);

   speed_state_e      state;
   logic              need_slow;
   logic              need_slow_q;
   logic              hs_sync;
   logic              ls_sync;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [TO_W-1:0]   to_nxt;

   assign need_slow = force_slow |
                      (cpu_valid && (cpu_bank == 8'h00) &&
                       (cpu_addr >= IO_LO) && (cpu_addr <= IO_HI));

   assign to_nxt  = (to_cnt == TO_TC) ? to_cnt : to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
   assign state_o = state;

   sync2 #(.RST_VAL(1'b0)) u_hs_sync (
      .hsclk_in (hsclk_in),
      .rst      (rst),
      .d        (hsclk_selected),
      .q        (hs_sync)
   );

   sync2 #(.RST_VAL(1'b1)) u_ls_sync (
      .hsclk_in (hsclk_in),
      .rst      (rst),
      .d        (lsclk_selected),
      .q        (ls_sync)
   );

   always_ff @(posedge hsclk_in or posedge rst) begin
      if (rst) begin
         state       <= ST_SLOW;
         hsclk_sel   <= 1'b0;
         rdy         <= 1'b1;
         err         <= 1'b0;
         need_slow_q <= 1'b0;
         hold_cnt    <= '0;
         to_cnt      <= '0;
      end else begin
         need_slow_q <= need_slow;
         case (state)
            ST_SLOW: begin
               // force_slow is a static override, so it also holds the counter
               // at zero directly instead of waiting for the decode register.
               if (need_slow_q || force_slow) begin
                  hold_cnt <= '0;
               end else if (hold_cnt != {HOLD_W{1'b1}}) begin
                  hold_cnt <= hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
               end
               if (!need_slow_q && !force_slow && (hold_cnt >= HOLD_TC)) begin
                  state     <= ST_REQ_FAST;
                  hsclk_sel <= 1'b1;
                  rdy       <= 1'b0;
                  to_cnt    <= '0;
               end
            end
            ST_REQ_FAST: begin
               to_cnt <= to_nxt;
               if (to_nxt == TO_TC) begin
                  err <= 1'b1;
               end
               if (need_slow_q) begin
                  state     <= ST_REQ_SLOW;
                  hsclk_sel <= 1'b0;
                  to_cnt    <= '0;
               end else if (hs_sync && !ls_sync) begin
                  state <= ST_FAST;
                  rdy   <= 1'b1;
               end
            end
            ST_FAST: begin
               if (need_slow_q) begin
                  state     <= ST_REQ_SLOW;
                  hsclk_sel <= 1'b0;
                  rdy       <= 1'b0;
                  to_cnt    <= '0;
               end
            end
            ST_REQ_SLOW: begin
               to_cnt <= to_nxt;
               if (to_nxt == TO_TC) begin
                  err <= 1'b1;
               end
               if (ls_sync && !hs_sync) begin
                  state    <= ST_SLOW;
                  rdy      <= 1'b1;
                  hold_cnt <= '0;
               end
            end
            default: begin
               state     <= ST_SLOW;
               hsclk_sel <= 1'b0;
               rdy       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_speed_sel.sv
// Directed bench: default instance for changeover flow and force_slow,
// short-hold / short-timeout instance for decode bounds, abort and watchdog.
module tb_clk_speed_sel;

   logic        hsclk_in;
   logic        rst1, rst2;
   logic        cpu_valid;
   logic [7:0]  cpu_bank;
   logic [15:0] cpu_addr;
   logic        force_slow;
   logic        hs1, ls1, hs2, ls2;
   logic        hsclk_sel1, rdy1, err1;
   logic        hsclk_sel2, rdy2, err2;
   logic [1:0]  state1, state2;

   int n_checks = 0;
   int n_fail   = 0;

   clk_speed_sel u_dut (
      .hsclk_in       (hsclk_in),
      .rst            (rst1),
      .cpu_valid      (cpu_valid),
      .cpu_bank       (cpu_bank),
      .cpu_addr       (cpu_addr),
      .force_slow     (force_slow),
      .hsclk_selected (hs1),
      .lsclk_selected (ls1),
      .hsclk_sel      (hsclk_sel1),
      .rdy            (rdy1),
      .err            (err1),
      .state_o        (state1)
   );

   clk_speed_sel #(.HOLD_CYCLES(1), .TIMEOUT(16)) u_dut2 (
      .hsclk_in       (hsclk_in),
      .rst            (rst2),
      .cpu_valid      (cpu_valid),
      .cpu_bank       (cpu_bank),
      .cpu_addr       (cpu_addr),
      .force_slow     (force_slow),
      .hsclk_selected (hs2),
      .lsclk_selected (ls2),
      .hsclk_sel      (hsclk_sel2),
      .rdy            (rdy2),
      .err            (err2),
      .state_o        (state2)
   );

   initial hsclk_in = 1'b0;
   always #5 hsclk_in = ~hsclk_in;

   task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle away from the edge.
   task automatic step(input int n);
      repeat (n) @(posedge hsclk_in);
      #2;
   endtask

   // Reset instance 2 with the given bus cycle present, release just after an edge.
   task automatic restart2(input logic [7:0] bank, input logic [15:0] addr);
      rst2      = 1'b1;
      cpu_valid = 1'b1;
      cpu_bank  = bank;
      cpu_addr  = addr;
      hs2       = 1'b0;
      ls2       = 1'b1;
      step(1);
      rst2 = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  bank;
      logic [15:0] addr;
      logic        fast;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{8'h00, 16'hFBFF, 1'b1};
      vecs[1] = '{8'h00, 16'hFC00, 1'b0};
      vecs[2] = '{8'h00, 16'hFEFF, 1'b0};
      vecs[3] = '{8'h00, 16'hFF00, 1'b1};
      vecs[4] = '{8'h01, 16'hFE40, 1'b1};

      rst1 = 1'b1; rst2 = 1'b1;
      cpu_valid = 1'b0; cpu_bank = 8'h00; cpu_addr = 16'h0000; force_slow = 1'b0;
      hs1 = 1'b0; ls1 = 1'b1; hs2 = 1'b0; ls2 = 1'b1;
      step(2);

      check_eq("rst_hsclk_sel", {15'd0, hsclk_sel1}, 16'd0);
      check_eq("rst_rdy",       {15'd0, rdy1},       16'd1);
      check_eq("rst_err",       {15'd0, err1},       16'd0);
      check_eq("rst_state",     {14'd0, state1},     16'd0);

      // Idle 8 cycles from reset, request fast on edge 9.
      rst1 = 1'b0;
      step(8);
      check_eq("idle8_hsclk_sel", {15'd0, hsclk_sel1}, 16'd0);
      check_eq("idle8_state",     {14'd0, state1},     16'd0);
      step(1);
      check_eq("edge9_hsclk_sel", {15'd0, hsclk_sel1}, 16'd1);
      check_eq("edge9_rdy",       {15'd0, rdy1},       16'd0);
      check_eq("edge9_state",     {14'd0, state1},     16'd1);
      hs1 = 1'b1; ls1 = 1'b0;
      step(2);
      check_eq("fb2_state", {14'd0, state1}, 16'd1);
      check_eq("fb2_rdy",   {15'd0, rdy1},   16'd0);
      step(1);
      check_eq("fast_state", {14'd0, state1}, 16'd2);
      check_eq("fast_rdy",   {15'd0, rdy1},   16'd1);

      // Slow I/O access while fast.
      cpu_valid = 1'b1; cpu_bank = 8'h00; cpu_addr = 16'hFE40;
      step(1);
      check_eq("io1_hsclk_sel", {15'd0, hsclk_sel1}, 16'd1);
      step(1);
      check_eq("io2_hsclk_sel", {15'd0, hsclk_sel1}, 16'd0);
      check_eq("io2_rdy",       {15'd0, rdy1},       16'd0);
      check_eq("io2_state",     {14'd0, state1},     16'd3);
      hs1 = 1'b0; ls1 = 1'b1;
      step(2);
      check_eq("ls2_state", {14'd0, state1}, 16'd3);
      step(1);
      check_eq("slow_state", {14'd0, state1}, 16'd0);
      check_eq("slow_rdy",   {15'd0, rdy1},   16'd1);
      rst1 = 1'b1;

      // Decode boundaries with a one-cycle hold.
      foreach (vecs[i]) begin
         restart2(vecs[i].bank, vecs[i].addr);
         step(4);
         check_eq($sformatf("dec_state_%0h_%0h", vecs[i].bank, vecs[i].addr),
                  {14'd0, state2}, vecs[i].fast ? 16'd1 : 16'd0);
         check_eq($sformatf("dec_sel_%0h_%0h", vecs[i].bank, vecs[i].addr),
                  {15'd0, hsclk_sel2}, {15'd0, vecs[i].fast});
      end

      // Abort a fast request with a slow access.
      restart2(8'h00, 16'hFBFF);
      step(2);
      check_eq("abort_pre_state", {14'd0, state2}, 16'd1);
      cpu_addr = 16'hFC00;
      step(1);
      check_eq("abort1_sel", {15'd0, hsclk_sel2}, 16'd1);
      step(1);
      check_eq("abort_state", {14'd0, state2},     16'd3);
      check_eq("abort_sel",   {15'd0, hsclk_sel2}, 16'd0);
      check_eq("abort_rdy",   {15'd0, rdy2},       16'd0);
      check_eq("abort_err",   {15'd0, err2},       16'd0);

      // Watchdog: feedback never moves.
      restart2(8'h00, 16'hFBFF);
      step(2);
      check_eq("to_entry_state", {14'd0, state2}, 16'd1);
      step(15);
      check_eq("to15_err", {15'd0, err2}, 16'd0);
      step(1);
      check_eq("to16_err",   {15'd0, err2},   16'd1);
      check_eq("to16_rdy",   {15'd0, rdy2},   16'd0);
      check_eq("to16_state", {14'd0, state2}, 16'd1);
      step(3);
      check_eq("to_hang_rdy", {15'd0, rdy2}, 16'd0);
      check_eq("to_hang_err", {15'd0, err2}, 16'd1);
      #1 rst2 = 1'b1;
      #1;
      check_eq("to_rst_sel",   {15'd0, hsclk_sel2}, 16'd0);
      check_eq("to_rst_rdy",   {15'd0, rdy2},       16'd1);
      check_eq("to_rst_err",   {15'd0, err2},       16'd0);
      check_eq("to_rst_state", {14'd0, state2},     16'd0);

      // force_slow held from reset.
      cpu_valid = 1'b0; cpu_addr = 16'h0000; force_slow = 1'b1;
      hs1 = 1'b0; ls1 = 1'b1;
      step(1);
      rst1 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         step(1);
         check_eq("fs_sel",  {15'd0, hsclk_sel1},         16'd0);
         check_eq("fs_hold", {8'd0, u_dut.hold_cnt},       16'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
